// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the multicycle multiply/divide unit.
//   mdu_op_t    - operation code driven on the op port
//   mdu_state_t - control FSM state encoding
//   is_div()    - true for DIV/DIVU
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

    function automatic logic is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle multiply/divide unit holding architectural HI/LO.
// One shift-add (multiply) or restoring (divide) iteration per clock on
// unsigned magnitudes; signs are re-applied in a single FIX cycle.
// Ports:
//   Clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     request an operation (sampled only when ready)
//   op        mdu_op_t operation code
//   lhs, rhs  multiplicand/dividend, multiplier/divisor
//   hi_we     MTHI write enable, lo_we MTLO write enable, wdata their data
//   hi_out    HI register, lo_out LO register
//   busy      operation in progress (CALC/FIX)
//   done      one-cycle completion pulse
//   div_zero  divide-by-zero flag, valid with done
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    mdu_state_t           state_q;
    logic [2*WIDTH-1:0]   acc_q;      // mult: {partial hi, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]     opb_q;      // multiplicand (mult) or divisor (div)
    logic [CNT_W-1:0]     cnt_q;
    logic                 is_div_q;
    logic                 neg_res_q;  // negate product / quotient in FIX
    logic                 neg_rem_q;  // negate remainder in FIX
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 busy_q, done_q, div_zero_q;

    mdu_op_t              op_in;
    logic                 signed_op, ready, accept, div_by_zero;
    logic [WIDTH-1:0]     lhs_abs, rhs_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     trial;
    logic [2*WIDTH-1:0]   mul_acc_d, div_acc_d, prod_d;
    logic [WIDTH-1:0]     quot_d, rem_d;

    always_comb begin
        op_in       = mdu_op_t'(op);
        signed_op   = ~op[0];
        ready       = (state_q == IDLE) || (state_q == DONE);
        accept      = ready & start;
        div_by_zero = is_div(op_in) && (rhs == '0);
        lhs_abs     = (signed_op && lhs[WIDTH-1]) ? -lhs : lhs;
        rhs_abs     = (signed_op && rhs[WIDTH-1]) ? -rhs : rhs;

        // Shift-add step: carry out of the upper-half add becomes the new MSB.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring step: the shifted remainder can need WIDTH+1 bits, so the
        // trial subtract carries one extra bit to expose the sign.
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        trial     = {1'b0, rem_sh} - {2'b00, opb_q};
        div_acc_d = trial[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_d = neg_res_q ? -acc_q : acc_q;
        quot_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    div_zero_q <= 1'b0;
                    if (accept) begin
                        acc_q     <= {{WIDTH{1'b0}}, is_div(op_in) ? lhs_abs : rhs_abs};
                        opb_q     <= is_div(op_in) ? rhs_abs : lhs_abs;
                        is_div_q  <= is_div(op_in);
                        neg_res_q <= signed_op & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
                        neg_rem_q <= signed_op & lhs[WIDTH-1];
                        cnt_q     <= CNT_W'(WIDTH);
                        if (div_by_zero) begin
                            // HI/LO keep their values; report straight away.
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        // MTHI/MTLO only land when no operation is being started.
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                CALC: begin
                    acc_q <= is_div_q ? div_acc_d : mul_acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_d;
                        lo_q <= quot_d;
                    end else begin
                        hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q <= prod_d[WIDTH-1:0];
                    end
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multicycle multiply/divide unit for the multicycle MIPS datapath; backs MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO.
- Holds architectural HI/LO registers.
- Computes one iteration per clock (shift-add multiply, restoring divide) under a start/busy/done handshake.
- The control FSM stalls on busy and reads HI/LO into the register-file write-data path.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
Clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request operation; sampled only when ready
op  input  2  operation code (mdu_op_t)
lhs  input  WIDTH  multiplicand / dividend (register A)
rhs  input  WIDTH  multiplier / divisor (register B)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
div_zero  output  1  divide-by-zero flag, valid with done

Behaviour:
- Reset (reset=0, async): state=IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, counter=0.
- Reset mid-operation aborts immediately, with no partial HI/LO update.
- FSM states: IDLE, CALC, FIX, DONE.
- ready = state is IDLE or DONE.
- busy=1 in CALC and FIX.
- done=1 only in DONE.
- div_zero=1 only in DONE, and only after a divide with rhs=0.
- Accept edge (ready & start):
  - Latch |lhs| and |rhs|; signed ops take the two's-complement magnitude, unsigned ops use the raw value.
  - Latch result signs: product/quotient sign = lhs[MSB]^rhs[MSB]; remainder sign = lhs[MSB]. Both are forced 0 for MULTU/DIVU.
  - Load counter=WIDTH, next state CALC.
- Divide by zero: if op is DIV/DIVU and rhs=0 at accept, go directly to DONE with div_zero=1. HI/LO unchanged. Latency 1 edge.
- CALC, one iteration per edge, counter decrements.
  - MULT*: if multiplier LSB is set, add multiplicand into the upper half of a 2*WIDTH accumulator (WIDTH+1-bit add, carry kept), then shift right 1.
  - DIV*: shift the {rem,quot} pair left 1; trial-subtract divisor from rem (WIDTH+1 bits); if non-negative, keep the difference and set the quotient LSB.
  - Leave CALC on the edge where counter reaches 0 (after exactly WIDTH iterations); next state FIX.
- FIX, one edge: apply sign correction (two's-complement negate where the latched sign is 1), then write HI/LO and go to DONE.
  - MULT*: {hi_out,lo_out} = 2*WIDTH product.
  - DIV*: lo_out = quotient, hi_out = remainder.
- Latency: done high in the cycle after edge WIDTH+2 counted from the accept edge (accept, WIDTH CALC edges, FIX edge). WIDTH=32 gives 34 edges after accept. HI/LO are valid when done=1 and remain stable until the next write.
- DONE lasts exactly one cycle; then IDLE, or CALC if start is accepted in DONE (back-to-back supported, done pulses do not merge).
- Signed overflow case DIV MIN/-1: quotient wraps to MIN, remainder 0. No flag raised.
- start while busy is ignored, with no queueing.
- hi_we/lo_we honored only when ready and no start is accepted in the same cycle; otherwise dropped.
- hi_we and lo_we together write both registers with wdata.
- op values are all legal; no X-propagation from unused accumulator bits.

Decomposition:
- Package mdu_pkg:
  - typedef enum logic[1:0] mdu_op_t {MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11}
  - typedef enum mdu_state_t {IDLE, CALC, FIX, DONE}
  - helper function is_div(op)
- No sub-module required: FSM and shared 2*WIDTH shift datapath live in one module.
- Optional reuse of the existing Registrador for HI/LO is not used, because the reset polarity differs.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF (WIDTH=32) -> done 34 edges after accept; HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 7/-2 -> LO=0xFFFFFFFD, HI=1.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> done the cycle after accept, div_zero=1, HI/LO unchanged.
- Back-to-back: start held through DONE -> second op accepted in DONE, two distinct done pulses 34 edges apart. Start pulsed while busy -> ignored, result from the first op only.
- reset driven low mid-CALC -> busy=0, HI=LO=0 asynchronously. lo_we=1, wdata=0x1234 in the same cycle as an accepted start -> LO not written. lo_we in IDLE -> LO=0x1234 next edge.
